// File: rtl/down_timer.sv
// Loadable down-counter with IDLE/RUN/EXPIRE control and a one-cycle done pulse.
// Define DOWN_TIMER_RELOAD_EN to restart automatically from the last loaded value.
module down_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_EXPIRE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] w_next_out;
    logic             w_ready;
    logic             w_accept;

`ifdef DOWN_TIMER_RELOAD_EN
    logic [WIDTH-1:0] r_reload;
    logic [WIDTH-1:0] w_next_reload;
`endif

    assign w_ready    = (r_state != S_RUN);
    assign w_accept   = load_valid && w_ready;

    assign load_ready = w_ready;
    assign out        = r_out;
    assign busy       = (r_state == S_RUN);
    assign done       = (r_state == S_EXPIRE);

    always_comb begin
        w_next_state = r_state;
        w_next_out   = r_out;
`ifdef DOWN_TIMER_RELOAD_EN
        w_next_reload = r_reload;
`endif
        if (clr) begin
            w_next_state = S_IDLE;
            w_next_out   = '0;
`ifdef DOWN_TIMER_RELOAD_EN
            w_next_reload = '0;
`endif
        end else if (w_accept) begin
            w_next_out = load_value;
`ifdef DOWN_TIMER_RELOAD_EN
            w_next_reload = load_value;
`endif
            if (load_value != '0)
                w_next_state = S_RUN;
            else
                w_next_state = S_EXPIRE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    w_next_state = S_IDLE;
                end
                S_RUN: begin
                    // a zero count in RUN is unreachable; treat it as expiry
                    if (en) begin
                        if (r_out > WIDTH'(1)) begin
                            w_next_out = r_out - WIDTH'(1);
                        end else begin
                            w_next_out   = '0;
                            w_next_state = S_EXPIRE;
                        end
                    end
                end
                S_EXPIRE: begin
`ifdef DOWN_TIMER_RELOAD_EN
                    if (r_reload != '0) begin
                        w_next_state = S_RUN;
                        w_next_out   = r_reload;
                    end else begin
                        w_next_state = S_IDLE;
                        w_next_out   = '0;
                    end
`else
                    w_next_state = S_IDLE;
                    w_next_out   = '0;
`endif
                end
                default: begin
                    w_next_state = S_IDLE;
                    w_next_out   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_out   <= '0;
        end else begin
            r_state <= w_next_state;
            r_out   <= w_next_out;
        end
    end

`ifdef DOWN_TIMER_RELOAD_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_reload <= '0;
        else
            r_reload <= w_next_reload;
    end
`endif

endmodule

// File: doc/down_timer.md
DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits (legal 2..16).
REQ-002 Port: clk  input  1  rising-edge clock; the block's only clock.
REQ-003 Port: rstn  input  1  asynchronous, active-low reset.
REQ-004 Port: clr  input  1  synchronous abort; return to IDLE.
REQ-005 Port: load_valid  input  1  load request.
REQ-006 Port: load_ready  output  1  load can be accepted this cycle.
REQ-007 Port: load_value  input  WIDTH  start value for the countdown.
REQ-008 Port: en  input  1  count enable; when low, the count holds.
REQ-009 Port: out  output  WIDTH  current count, registered.
REQ-010 Port: busy  output  1  high when the FSM is in RUN.
REQ-011 Port: done  output  1  one-cycle expiry pulse, registered.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and EXPIRE; done = (state==EXPIRE) and busy = (state==RUN).
REQ-013 load_ready SHALL be high in IDLE and EXPIRE and low in RUN; load_valid in RUN SHALL be ignored with no state change.
REQ-014 A load is accepted on a clk edge when load_valid && load_ready && !clr; the same edge SHALL set out to load_value and capture load_value into an internal reload register.
REQ-015 A load with load_value != 0 SHALL move the FSM to RUN; a load with load_value == 0 SHALL move it to EXPIRE with out = 0, giving a done pulse one cycle after acceptance.
REQ-016 In RUN, with en high and out > 1, each edge SHALL decrement out by exactly 1.
REQ-017 In RUN, with en high and out == 1, the edge SHALL set out = 0 and move the FSM to EXPIRE.
REQ-018 In RUN, with en low, out and the state SHALL hold.
REQ-019 out SHALL never wrap below 0, and no underflow SHALL occur in any state.
REQ-020 Latency: for load value L > 0 with en held high, done SHALL be high in the cycle following the L-th edge after the accepting edge, i.e. during the cycle out first reads 0.
REQ-021 EXPIRE SHALL last exactly one cycle; its exit is given in REQ-027/028 unless a load is accepted, in which case the load takes priority (REQ-014/015).
REQ-022 clr high at an edge SHALL force state IDLE and out = 0, overriding a load, the count and the reload; the reload register SHALL be cleared.
REQ-023 In IDLE, out SHALL hold its value (0 after reset or clr, 0 after expiry).
REQ-024 Priority per edge: rstn (async) > clr > load accept > count/expiry.

Reset
REQ-025 While rstn is low, asynchronously and regardless of clk: state = IDLE, out = 0, reload register = 0, done = 0, busy = 0, load_ready = 1.
REQ-026 After rstn rises, the first edge SHALL already accept a load; asserting rstn mid-RUN SHALL abort the countdown immediately without a done pulse.

Configuration
REQ-027 With macro DOWN_TIMER_RELOAD_EN defined, exit from EXPIRE without a load SHALL go to RUN with out = the reload register, repeating with period L+1 cycles; if the reload register is 0, EXPIRE SHALL go to IDLE.
REQ-028 Without DOWN_TIMER_RELOAD_EN, exit from EXPIRE without a load SHALL always go to IDLE with out = 0, and the reload register MAY be omitted.

Verification
REQ-029 Release reset, load 5 with en=1 -> out reads 5,4,3,2,1,0 on successive edges; done=1 only in the cycle out first reads 0; busy=1 while out is 5..1; FSM then in IDLE.
REQ-030 Load 4, en toggles 1,0,0,1,1,1 -> out reads 4,3,3,3,2,1,0; done fires once.
REQ-031 Load 0 -> done=1 on the next cycle, out=0; load_valid pulsed mid-RUN of load 6 -> ignored, load_ready=0, count is unaffected.
REQ-032 clr asserted when out=2 in RUN while load_valid=1 -> next cycle out=0, IDLE, no done; rstn pulsed low between edges mid-RUN -> out=0 immediately, no done.
REQ-033 Load issued in the EXPIRE cycle with value 3 -> RUN with out=3 (load wins over reload or IDLE).
REQ-034 With DOWN_TIMER_RELOAD_EN defined, load 3 with en=1 -> done pulses every 4 cycles and out sequence is 3,2,1,0,3,2,1,0,...; without the macro -> a single done, then IDLE.
